ecp3_phase_ctlr: RTL

- Responder side of the ECP3 clock-alignment loop.
- Consumes the 2-bit align_status reported by the clock-synchronisation block. Steps the PLL phase select until eclk/sclk alignment reads good, then monitors it.
- Sequences ECLKSYNC stop and datapath reset around every phase move.
- Reports good/err to the DDR PHY. Runs in the refclk domain, so it never depends on the clocks it rotates.

---
 rtl/ecp3_phase_ctlr.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ecp3_phase_ctlr.sv
// ECP3 clock-alignment responder: steps the PLL phase until eclk/sclk alignment reads
// good, wrapping each move in an ECLKSYNC stop and a datapath reset, then monitors lock.
module ecp3_phase_ctlr #(
  parameter logic [1:0] GOOD_CODE     = 2'b01,
  parameter int         SETTLE_CYCLES = 128,
  parameter int         STOP_CYCLES   = 8,
  parameter int         RST_CYCLES    = 8,
  parameter int         MON_CYCLES    = 16,
  parameter int         MAX_STEPS     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lock,
  input  logic [1:0] align_status,
  input  logic       reset_datapath,
  output logic [3:0] phase,
  output logic       stop_out,
  output logic       reset_datapath_out,
  output logic       good,
  output logic       err
);
  localparam int CW = 16;
  localparam int SW = $clog2(MAX_STEPS + 1);
  localparam int MW = $clog2(MON_CYCLES + 1);

  typedef enum logic [2:0] {
    S_WAIT_LOCK, S_DPRST, S_SETTLE, S_SAMPLE, S_STOP, S_LOCKED, S_FAIL
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] steps_q, steps_d;
  logic [MW-1:0] mis_q, mis_d;
  logic [3:0]    phase_q, phase_d;
  logic          stop_q, stop_d;
  logic          rdo_q, rdo_d;
  logic          good_q, good_d;
  logic          err_q, err_d;
  logic          status_ok;

  assign status_ok = (align_status == GOOD_CODE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT_LOCK;
      cnt_q   <= '0;
      steps_q <= '0;
      mis_q   <= '0;
      phase_q <= '0;
      stop_q  <= 1'b0;
      rdo_q   <= 1'b1;
      good_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      steps_q <= steps_d;
      mis_q   <= mis_d;
      phase_q <= phase_d;
      stop_q  <= stop_d;
      rdo_q   <= rdo_d;
      good_q  <= good_d;
      err_q   <= err_d;
    end
  end

  // cnt_q counts down from N-1 so a timed state lasts exactly N cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    steps_d = steps_q;
    mis_d   = mis_q;
    case (state_q)
      S_WAIT_LOCK: begin
        if (lock) begin
          state_d = S_DPRST;
          cnt_d   = CW'(RST_CYCLES - 1);
        end
      end
      S_DPRST: begin
        if (cnt_q == '0) begin
          state_d = S_SETTLE;
          cnt_d   = CW'(SETTLE_CYCLES - 1);
        end else cnt_d = cnt_q - CW'(1);
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_SAMPLE;
        else cnt_d = cnt_q - CW'(1);
      end
      S_SAMPLE: begin
        if (status_ok) begin
          state_d = S_LOCKED;
          mis_d   = '0;
        end else if (steps_q == SW'(MAX_STEPS - 1)) begin
          state_d = S_FAIL;
        end else begin
          state_d = S_STOP;
          steps_d = steps_q + SW'(1);
          cnt_d   = CW'(STOP_CYCLES - 1);
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          state_d = S_DPRST;
          cnt_d   = CW'(RST_CYCLES - 1);
        end else cnt_d = cnt_q - CW'(1);
      end
      S_LOCKED: begin
        steps_d = '0;
        if (reset_datapath) begin
          state_d = S_DPRST;
          cnt_d   = CW'(RST_CYCLES - 1);
        end else if (status_ok) begin
          mis_d = '0;
        end else if (mis_q == MW'(MON_CYCLES - 1)) begin
          state_d = S_STOP;
          cnt_d   = CW'(STOP_CYCLES - 1);
          mis_d   = '0;
        end else begin
          mis_d = mis_q + MW'(1);
        end
      end
      S_FAIL: ;
      default: state_d = S_WAIT_LOCK;
    endcase
    // Lock loss outranks everything; phase and steps survive so the search resumes.
    if (!lock && state_q != S_FAIL) state_d = S_WAIT_LOCK;
  end

  // Outputs are registered copies decoded from the state being entered.
  always_comb begin
    phase_d = phase_q;
    if (state_d == S_STOP && state_q != S_STOP) phase_d = phase_q + 4'd1;
    stop_d = (state_d == S_STOP);
    rdo_d  = (state_d == S_WAIT_LOCK) || (state_d == S_DPRST);
    good_d = (state_d == S_LOCKED);
    err_d  = (state_d == S_FAIL);
  end

  assign phase              = phase_q;
  assign stop_out           = stop_q;
  assign reset_datapath_out = rdo_q;
  assign good               = good_q;
  assign err                = err_q;
endmodule
